// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and helpers for the 10GBASE-R receive block aligner.
// Covers the 66-bit block geometry, the slip offset range and the sync-header codes.
package eth_phy_10g_pkg;

    localparam int              BLOCK_W    = 66;
    localparam int              OFFSET_W   = 7;
    localparam logic [1:0]      SYNC_DATA  = 2'b10;
    localparam logic [1:0]      SYNC_CTRL  = 2'b01;
    localparam logic [OFFSET_W-1:0] MAX_OFFSET = 7'd65;

    // Some SERDES deliver the word MSB-first on the wire; this maps it back to bit 0 = oldest.
    function automatic logic [BLOCK_W-1:0] bit_reverse66(input logic [BLOCK_W-1:0] d);
        logic [BLOCK_W-1:0] r;
        for (int i = 0; i < BLOCK_W; i++) begin
            r[i] = d[BLOCK_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_bitslip_shifter.sv
// Combinational 132-to-66 window select.
// Bit 0 of the window is the bit at position i_offset in {current, previous}.
module eth_phy_10g_rx_bitslip_shifter
    import eth_phy_10g_pkg::*;
(
    input  logic [2*BLOCK_W-1:0] i_win,
    input  logic [OFFSET_W-1:0]  i_offset,
    output logic [BLOCK_W-1:0]   o_block
);

    logic [2*BLOCK_W-1:0] w_shifted;

    assign w_shifted = i_win >> i_offset;
    assign o_block   = w_shifted[BLOCK_W-1:0];

endmodule

// File: rtl/eth_phy_10g_rx_bitslip_aligner.sv
// 66b block aligner: realigns raw SERDES words by a bit offset that is stepped on bitslip requests.
// Optional macro ALIGNER_SLIP_STATS_EN adds a saturating accepted-slip counter with a synchronous clear.
module eth_phy_10g_rx_bitslip_aligner
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int HDR_WIDTH    = 2,
    parameter int BIT_REVERSE  = 0,
    parameter int SLIP_HOLDOFF = 8
)
(
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic [BLOCK_W-1:0]    raw_data,
    input  logic                  raw_valid,
    input  logic                  serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0] serdes_rx_data,
    output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_valid,
    output logic [OFFSET_W-1:0]   slip_offset,
    output logic                  slip_busy
`ifdef ALIGNER_SLIP_STATS_EN
    ,
    input  logic                  slip_count_clr,
    output logic [15:0]           slip_count
`endif
);

    localparam int HC_W = (SLIP_HOLDOFF < 1) ? 1 : $clog2(SLIP_HOLDOFF + 1);

    logic [BLOCK_W-1:0]    w_raw;
    logic [BLOCK_W-1:0]    w_win;
    logic                  w_slip_accept;

    logic [BLOCK_W-1:0]    r_hold;
    logic [DATA_WIDTH-1:0] r_data;
    logic [HDR_WIDTH-1:0]  r_hdr;
    logic                  r_valid;
    logic [OFFSET_W-1:0]   r_offset;
    logic [HC_W-1:0]       r_holdoff;
    logic                  r_slip_q;

    assign w_raw = (BIT_REVERSE != 0) ? bit_reverse66(raw_data) : raw_data;

    eth_phy_10g_rx_bitslip_shifter u_shifter (
        .i_win    ({w_raw, r_hold}),
        .i_offset (r_offset),
        .o_block  (w_win)
    );

    // Only a 0->1 transition counts, and only once the previous slip has settled.
    assign w_slip_accept = serdes_rx_bitslip && !r_slip_q && (r_holdoff == '0);

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_hold  <= '0;
            r_data  <= '0;
            r_hdr   <= '0;
            r_valid <= 1'b0;
        end else if (raw_valid) begin
            r_hold  <= w_raw;
            r_data  <= w_win[BLOCK_W-1:HDR_WIDTH];
            r_hdr   <= w_win[HDR_WIDTH-1:0];
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    // The window above uses the pre-slip offset; a new offset applies from the next word.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_slip_q  <= 1'b0;
            r_offset  <= '0;
            r_holdoff <= '0;
        end else begin
            r_slip_q <= serdes_rx_bitslip;
            if (w_slip_accept) begin
                r_offset  <= (r_offset == MAX_OFFSET) ? '0 : r_offset + 1'b1;
                r_holdoff <= HC_W'(SLIP_HOLDOFF);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 1'b1;
            end
        end
    end

`ifdef ALIGNER_SLIP_STATS_EN
    logic [15:0] r_slip_count;

    always_ff @(posedge rx_clk) begin
        if (rx_rst || slip_count_clr) begin
            r_slip_count <= '0;
        end else if (w_slip_accept && (r_slip_count != 16'hFFFF)) begin
            r_slip_count <= r_slip_count + 16'd1;
        end
    end

    assign slip_count = r_slip_count;
`endif

    assign serdes_rx_data  = r_data;
    assign serdes_rx_hdr   = r_hdr;
    assign serdes_rx_valid = r_valid;
    assign slip_offset     = r_offset;
    assign slip_busy       = (r_holdoff != '0);

endmodule

// File: tb/tb_eth_phy_10g_rx_bitslip_aligner.sv
// Directed + randomized bench for the 66b bitslip aligner, checked against a bit-window reference model.
module tb_eth_phy_10g_rx_bitslip_aligner;

    localparam int HOLD = 8;

    logic        rx_clk = 1'b0;
    logic        rx_rst = 1'b0;
    logic [65:0] raw_data = '0;
    logic        raw_valid = 1'b0;
    logic        serdes_rx_bitslip = 1'b0;
    logic [63:0] serdes_rx_data;
    logic [1:0]  serdes_rx_hdr;
    logic        serdes_rx_valid;
    logic [6:0]  slip_offset;
    logic        slip_busy;
`ifdef ALIGNER_SLIP_STATS_EN
    logic        slip_count_clr = 1'b0;
    logic [15:0] slip_count;
`endif

    eth_phy_10g_rx_bitslip_aligner #(
        .DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(0), .SLIP_HOLDOFF(HOLD)
    ) dut (
        .rx_clk            (rx_clk),
        .rx_rst            (rx_rst),
        .raw_data          (raw_data),
        .raw_valid         (raw_valid),
        .serdes_rx_bitslip (serdes_rx_bitslip),
        .serdes_rx_data    (serdes_rx_data),
        .serdes_rx_hdr     (serdes_rx_hdr),
        .serdes_rx_valid   (serdes_rx_valid),
        .slip_offset       (slip_offset),
        .slip_busy         (slip_busy)
`ifdef ALIGNER_SLIP_STATS_EN
        ,
        .slip_count_clr    (slip_count_clr),
        .slip_count        (slip_count)
`endif
    );

    always #5 rx_clk = ~rx_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: bit stream history as the last word, offset as an integer 0..65.
    logic [65:0] m_h;
    int          m_off, m_hold, m_slips;
    logic        m_prev;
    logic [63:0] m_data;
    logic [1:0]  m_hdr;
    logic        m_valid;
    logic        tb_clr = 1'b0;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h = '0; m_off = 0; m_hold = 0; m_slips = 0; m_prev = 1'b0;
        m_data = '0; m_hdr = '0; m_valid = 1'b0;
    endtask

    task automatic check_all();
        chk("valid",  66'(serdes_rx_valid), 66'(m_valid));
        chk("data",   66'(serdes_rx_data),  66'(m_data));
        chk("hdr",    66'(serdes_rx_hdr),   66'(m_hdr));
        chk("offset", 66'(slip_offset),     66'(m_off));
        chk("busy",   66'(slip_busy),       66'(m_hold != 0));
`ifdef ALIGNER_SLIP_STATS_EN
        chk("slip_count", 66'(slip_count), 66'(m_slips));
`endif
    endtask

    task automatic step(input logic v, input logic [65:0] d, input logic s);
        logic [131:0] cat;
        bit acc;
        raw_valid = v; raw_data = d; serdes_rx_bitslip = s;
`ifdef ALIGNER_SLIP_STATS_EN
        slip_count_clr = tb_clr;
`endif
        @(posedge rx_clk);
        if (v) begin
            cat = {d, m_h} >> m_off;
            m_hdr = cat[1:0]; m_data = cat[65:2]; m_valid = 1'b1; m_h = d;
        end else begin
            m_valid = 1'b0;
        end
        acc = s && !m_prev && (m_hold == 0);
        if (acc) begin
            m_off  = (m_off + 1) % 66;
            m_hold = HOLD;
        end else if (m_hold > 0) begin
            m_hold--;
        end
`ifdef ALIGNER_SLIP_STATS_EN
        if (tb_clr) m_slips = 0;
        else if (acc && m_slips < 65535) m_slips++;
`endif
        m_prev = s;
        #1 check_all();
    endtask

    task automatic do_reset();
        rx_rst = 1'b1;
        @(posedge rx_clk);
        model_reset();
        #1 check_all();
        rx_rst = 1'b0;
    endtask

    // One accepted-slip pulse: one cycle high then holdoff-long low, streaming word d.
    task automatic pulse(input logic [65:0] d);
        step(1'b1, d, 1'b1);
        for (int k = 0; k < HOLD; k++) step(1'b1, d, 1'b0);
    endtask

    initial begin
        logic [65:0] blk, rot5, w0, ref0;
        int busy_cnt;
        model_reset();
        blk  = {64'h0707070707070707, 2'b01};
        rot5 = {blk[60:0], blk[65:61]};

        // 1: reset state and offset-0 latency
        rx_rst = 1'b1; raw_valid = 1'b1; raw_data = 66'h3_FFFF_FFFF_FFFF_FFFF;
        @(posedge rx_clk); @(posedge rx_clk);
        model_reset();
        #1 check_all();
        rx_rst = 1'b0;
        step(1'b1, blk, 1'b0);
        step(1'b1, blk, 1'b0);
        chk("t1_hdr",   66'(serdes_rx_hdr),  66'(2'b01));
        chk("t1_data",  66'(serdes_rx_data), 66'(64'h0707070707070707));
        chk("t1_valid", 66'(serdes_rx_valid), 66'd1);
        chk("t1_off",   66'(slip_offset),    66'd0);

        // 2: stream rotated by 5, five slips realign it
        for (int p = 0; p < 5; p++) pulse(rot5);
        chk("t2_off", 66'(slip_offset), 66'd5);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, rot5, 1'b0);
            chk("t2_hdr",  66'(serdes_rx_hdr),  66'(2'b01));
            chk("t2_data", 66'(serdes_rx_data), 66'(64'h0707070707070707));
        end

        // 3: level held high counts once; busy lasts exactly HOLD cycles
        do_reset();
        busy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, blk, 1'b1);
            if (slip_busy) busy_cnt++;
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, blk, 1'b0);
            if (slip_busy) busy_cnt++;
        end
        chk("t3_off",  66'(slip_offset), 66'd1);
        chk("t3_busy_cycles", 66'(busy_cnt), 66'(HOLD));

        // 4: edge during holdoff dropped; edge after holdoff accepted
        do_reset();
        step(1'b1, blk, 1'b1);
        step(1'b1, blk, 1'b0);
        step(1'b1, blk, 1'b0);
        step(1'b1, blk, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, blk, 1'b0);
        chk("t4_off_a", 66'(slip_offset), 66'd1);
        step(1'b1, blk, 1'b1);
        chk("t4_off_b", 66'(slip_offset), 66'd2);
        step(1'b1, blk, 1'b0);

        // 5: 66 slips wrap back to offset 0 with identical output
        do_reset();
        w0 = {$urandom, $urandom, 2'($urandom)};
        step(1'b1, w0, 1'b0);
        step(1'b1, w0, 1'b0);
        ref0 = {serdes_rx_data, serdes_rx_hdr};
        for (int p = 0; p < 66; p++) pulse(w0);
        chk("t5_off", 66'(slip_offset), 66'd0);
        step(1'b1, w0, 1'b0);
        chk("t5_wrap_out", {serdes_rx_data, serdes_rx_hdr}, ref0);
`ifdef ALIGNER_SLIP_STATS_EN
        chk("t5_count", 66'(slip_count), 66'd66);
`endif

        // 6: reset mid-holdoff at offset 17
        do_reset();
        for (int p = 0; p < 16; p++) pulse(blk);
        step(1'b1, blk, 1'b1);
        chk("t6_off_pre",  66'(slip_offset), 66'd17);
        chk("t6_busy_pre", 66'(slip_busy),   66'd1);
        do_reset();
        chk("t6_off",   66'(slip_offset),     66'd0);
        chk("t6_busy",  66'(slip_busy),       66'd0);
        chk("t6_valid", 66'(serdes_rx_valid), 66'd0);
        chk("t6_data",  66'(serdes_rx_data),  66'd0);
        chk("t6_hdr",   66'(serdes_rx_hdr),   66'd0);

        // Randomized traffic: gaps in raw_valid, sporadic slip levels, slips with valid low
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(3, 0) != 0),
                 {$urandom, $urandom, 2'($urandom)},
                 ($urandom_range(4, 0) == 0));
        end

`ifdef ALIGNER_SLIP_STATS_EN
        tb_clr = 1'b1;
        step(1'b1, blk, 1'b1);
        tb_clr = 1'b0;
        step(1'b1, blk, 1'b0);
        chk("clr_count", 66'(slip_count), 66'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
